// File: rtl/score_leaderboard.sv
// Sorted high-score table: keeps the best NUM_ENTRIES non-guest BCD scores with
// UIDs fetched from a synchronous ROM; rank 0 and a rank read port are exposed.
module score_leaderboard #(
  parameter int  NUM_ENTRIES = 4,
  parameter int  DIGITS      = 2,
  parameter int  IDX_W       = 5,
  parameter int  UID_W       = 16,
  parameter int  ROM_LAT     = 1,
  localparam int RANK_W      = $clog2(NUM_ENTRIES),
  localparam int SCORE_W     = 4 * DIGITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sub_valid,
  output logic               sub_ready,
  input  logic               sub_guest,
  input  logic [IDX_W-1:0]   sub_idx,
  input  logic [SCORE_W-1:0] sub_score,
  input  logic               clr_table,
  output logic [IDX_W-1:0]   rom_addr,
  input  logic [UID_W-1:0]   rom_data,
  input  logic [RANK_W-1:0]  rd_rank,
  output logic               rd_valid,
  output logic [UID_W-1:0]   rd_uid,
  output logic [SCORE_W-1:0] rd_score,
  output logic [UID_W-1:0]   top_uid,
  output logic [SCORE_W-1:0] top_score,
  output logic               done,
  output logic               done_placed,
  output logic [RANK_W-1:0]  done_rank,
  output logic               err_bcd
);

  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_INSERT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q;
  logic [IDX_W-1:0]     rom_addr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 placed_q;
  logic [RANK_W-1:0]    rank_q;
  logic                 err_q;

  logic                 valid_q [NUM_ENTRIES];
  logic [UID_W-1:0]     uid_q   [NUM_ENTRIES];
  logic [SCORE_W-1:0]   tscore_q[NUM_ENTRIES];
  logic                 valid_d [NUM_ENTRIES];
  logic [UID_W-1:0]     uid_d   [NUM_ENTRIES];
  logic [SCORE_W-1:0]   tscore_d[NUM_ENTRIES];

  logic                 accept;
  logic [RANK_W:0]      ins_pos;
  logic                 ins_fits;

  function automatic logic bcd_ok(input logic [SCORE_W-1:0] s);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (s[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign accept = sub_valid && (state_q == S_IDLE) && !clr_table;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (!bcd_ok(sub_score) || sub_guest) ? S_DONE : S_WAIT;
      S_WAIT:   if (cnt_q == '0) state_d = S_INSERT;
      S_INSERT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (clr_table) state_d = S_IDLE;
  end

  always_comb begin
    sub_ready   = (state_q == S_IDLE);
    done        = (state_q == S_DONE);
    done_placed = done && placed_q;
    done_rank   = (done && placed_q) ? rank_q : '0;
    err_bcd     = done && err_q;
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      cnt_q      <= '0;
      placed_q   <= 1'b0;
      rank_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        rom_addr_q <= sub_idx;
        cnt_q      <= CNT_W'(ROM_LAT - 1);
        placed_q   <= 1'b0;
        rank_q     <= '0;
        err_q      <= !bcd_ok(sub_score);
      end else if (state_q == S_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == S_INSERT && !clr_table) begin
        placed_q <= ins_fits;
        rank_q   <= ins_fits ? ins_pos[RANK_W-1:0] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) score_q <= sub_score;
  end

  // Equal scores count as better, so a tie lands below the existing entry
  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && tscore_q[i] >= score_q) ins_pos = ins_pos + (RANK_W+1)'(1);
    end
    ins_fits = ins_pos < (RANK_W+1)'(NUM_ENTRIES);

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      uid_d[i]    = uid_q[i];
      tscore_d[i] = tscore_q[i];
    end
    if (state_q == S_INSERT && ins_fits) begin
      for (int i = 1; i < NUM_ENTRIES; i++) begin
        if ((RANK_W+1)'(i) > ins_pos) begin
          valid_d[i]  = valid_q[i-1];
          uid_d[i]    = uid_q[i-1];
          tscore_d[i] = tscore_q[i-1];
        end
      end
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if ((RANK_W+1)'(i) == ins_pos) begin
          valid_d[i]  = 1'b1;
          uid_d[i]    = rom_data;
          tscore_d[i] = score_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (rst || clr_table) begin
        valid_q[i]  <= 1'b0;
        uid_q[i]    <= '0;
        tscore_q[i] <= '0;
      end else begin
        valid_q[i]  <= valid_d[i];
        uid_q[i]    <= uid_d[i];
        tscore_q[i] <= tscore_d[i];
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rd_valid  = valid_q[rd_rank];
  assign rd_uid    = valid_q[rd_rank] ? uid_q[rd_rank] : '0;
  assign rd_score  = valid_q[rd_rank] ? tscore_q[rd_rank] : '0;
  assign top_uid   = valid_q[0] ? uid_q[0] : '0;
  assign top_score = valid_q[0] ? tscore_q[0] : '0;

endmodule

// File: tb/tb_score_leaderboard.sv
// Bench for score_leaderboard: directed scenarios plus random submissions compared
// against a queue-based leaderboard model.
module tb_score_leaderboard;

  localparam int N       = 4;
  localparam int DIGITS  = 2;
  localparam int IDX_W   = 5;
  localparam int UID_W   = 16;
  localparam int ROM_LAT = 1;
  localparam int RANK_W  = 2;
  localparam int SW      = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sub_valid = 1'b0;
  logic              sub_ready;
  logic              sub_guest = 1'b0;
  logic [IDX_W-1:0]  sub_idx = '0;
  logic [SW-1:0]     sub_score = '0;
  logic              clr_table = 1'b0;
  logic [IDX_W-1:0]  rom_addr;
  logic [UID_W-1:0]  rom_data;
  logic [RANK_W-1:0] rd_rank;
  logic              rd_valid;
  logic [UID_W-1:0]  rd_uid;
  logic [SW-1:0]     rd_score;
  logic [UID_W-1:0]  top_uid;
  logic [SW-1:0]     top_score;
  logic              done;
  logic              done_placed;
  logic [RANK_W-1:0] done_rank;
  logic              err_bcd;

  score_leaderboard #(
    .NUM_ENTRIES(N), .DIGITS(DIGITS), .IDX_W(IDX_W), .UID_W(UID_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .sub_valid(sub_valid), .sub_ready(sub_ready),
    .sub_guest(sub_guest), .sub_idx(sub_idx), .sub_score(sub_score),
    .clr_table(clr_table), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_rank(rd_rank), .rd_valid(rd_valid), .rd_uid(rd_uid), .rd_score(rd_score),
    .top_uid(top_uid), .top_score(top_score), .done(done), .done_placed(done_placed),
    .done_rank(done_rank), .err_bcd(err_bcd)
  );

  always #5 clk = ~clk;

  logic [UID_W-1:0] rom [32];
  logic [UID_W-1:0] rom_pipe [ROM_LAT];
  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'(32'hC000 + i * 32'h0101);
    rom[3] = 16'h1234;
  end
  always @(posedge clk) begin
    rom_pipe[0] <= rom[rom_addr];
    for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  typedef struct { int uid; int score; } ent_t;
  ent_t tbl[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit busy     = 1'b1;
  bit hold_rd  = 1'b0;
  logic [RANK_W-1:0] lit_rank = '0;
  logic [RANK_W-1:0] rnd_rank = '0;
  assign rd_rank = hold_rd ? lit_rank : rnd_rank;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit score_valid(input int s);
    for (int d = 0; d < DIGITS; d++) if (((s >> (4*d)) & 15) > 9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_rank(input int s);
    int p = 0;
    foreach (tbl[i]) if (tbl[i].score >= s) p++;
    return p;
  endfunction

  // Whenever no submission is in flight the visible table must match the model
  always @(negedge clk) begin
    if (!busy) begin
      int r;
      r = int'(rd_rank);
      chk("idle_ready", 32'(sub_ready), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
      chk("top_uid", 32'(top_uid), (tbl.size() > 0) ? 32'(tbl[0].uid) : 32'd0);
      chk("top_score", 32'(top_score), (tbl.size() > 0) ? 32'(tbl[0].score) : 32'd0);
      chk("rd_valid", 32'(rd_valid), (r < tbl.size()) ? 32'd1 : 32'd0);
      chk("rd_uid", 32'(rd_uid), (r < tbl.size()) ? 32'(tbl[r].uid) : 32'd0);
      chk("rd_score", 32'(rd_score), (r < tbl.size()) ? 32'(tbl[r].score) : 32'd0);
      rnd_rank = RANK_W'($urandom_range(0, N-1));
    end
  end

  task automatic submit(input int idx, input int score, input bit guest, input bit noise,
                        output bit pl, output int rk, output int lat, output bit er);
    int exp_p, exp_lat;
    bit exp_err, exp_pl;
    ent_t e;
    exp_err = !score_valid(score);
    exp_p   = model_rank(score);
    exp_pl  = !exp_err && !guest && (exp_p < N);
    exp_lat = (exp_err || guest) ? 1 : ROM_LAT + 2;
    busy = 1'b1;
    sub_valid = 1'b1; sub_idx = IDX_W'(idx); sub_score = SW'(score); sub_guest = guest;
    @(posedge clk); #1;
    sub_valid = noise;
    sub_idx = IDX_W'($urandom); sub_score = SW'($urandom); sub_guest = 1'($urandom);
    if (!exp_err && !guest) chk("rom_addr", 32'(rom_addr), 32'(idx));
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = k; break; end
    end
    chk("done_latency", 32'(lat), 32'(exp_lat));
    pl = done_placed; rk = int'(done_rank); er = err_bcd;
    chk("done_placed", 32'(pl), 32'(exp_pl));
    chk("done_rank", 32'(rk), exp_pl ? 32'(exp_p) : 32'd0);
    chk("err_bcd", 32'(er), 32'(exp_err));
    if (exp_pl) begin
      e.uid = int'(rom[idx]); e.score = score;
      tbl.insert(exp_p, e);
      if (tbl.size() > N) tbl.delete(N);
    end
    @(posedge clk); #1;
    sub_valid = 1'b0;
    busy = 1'b0;
  endtask

  // mode 0: clr_table during WAIT, 1: rst during INSERT, 2: clr_table with sub_valid
  task automatic abort_test(input int mode, input int idx, input int score);
    bit seen;
    busy = 1'b1;
    sub_valid = 1'b1; sub_idx = IDX_W'(idx); sub_score = SW'(score); sub_guest = 1'b0;
    if (mode == 2) clr_table = 1'b1;
    @(posedge clk); #1;
    sub_valid = 1'b0;
    if (mode == 0) begin
      clr_table = 1'b1; @(posedge clk); #1; clr_table = 1'b0;
    end else if (mode == 1) begin
      repeat (ROM_LAT) @(posedge clk);
      #1; rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end else begin
      clr_table = 1'b0;
    end
    tbl.delete();
    chk("abort_ready", 32'(sub_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    @(posedge clk); #1;
    busy = 1'b0;
  endtask

  task automatic chk_rank_lit(input int r, input bit v, input int uid, input int score);
    hold_rd = 1'b1; lit_rank = RANK_W'(r); #1;
    chk("lit_rd_valid", 32'(rd_valid), 32'(v));
    chk("lit_rd_uid", 32'(rd_uid), 32'(uid));
    chk("lit_rd_score", 32'(rd_score), 32'(score));
    hold_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pl, er;
    int rk, lat;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_ready", 32'(sub_ready), 32'd1);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_top_score", 32'(top_score), 32'd0);
    for (int r = 0; r < N; r++) chk_rank_lit(r, 1'b0, 0, 0);
    busy = 1'b0;
    @(posedge clk); #1;

    submit(3, 'h42, 1'b0, 1'b0, pl, rk, lat, er);
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_placed", 32'(pl), 32'd1);
    chk("t2_rank", 32'(rk), 32'd0);
    chk("t2_top_uid", 32'(top_uid), 32'h1234);
    chk("t2_top_score", 32'(top_score), 32'h42);

    submit(7, 'h57, 1'b0, 1'b0, pl, rk, lat, er);  chk("t3_rank_57", 32'(rk), 32'd0);
    submit(9, 'h42, 1'b0, 1'b1, pl, rk, lat, er);  chk("t3_rank_42", 32'(rk), 32'd2);
    submit(11, 'h10, 1'b0, 1'b0, pl, rk, lat, er); chk("t3_rank_10", 32'(rk), 32'd3);
    submit(12, 'h99, 1'b0, 1'b0, pl, rk, lat, er); chk("t3_rank_99", 32'(rk), 32'd0);
    chk_rank_lit(0, 1'b1, 'hCC0C, 'h99);
    chk_rank_lit(1, 1'b1, 'hC707, 'h57);
    chk_rank_lit(2, 1'b1, 'h1234, 'h42);
    chk_rank_lit(3, 1'b1, 'hC909, 'h42);

    submit(5, 'h05, 1'b0, 1'b0, pl, rk, lat, er);  chk("t4_low_placed", 32'(pl), 32'd0);
    submit(6, 'h42, 1'b0, 1'b0, pl, rk, lat, er);  chk("t4_tie_placed", 32'(pl), 32'd0);
    chk_rank_lit(3, 1'b1, 'hC909, 'h42);

    submit(8, 'h99, 1'b1, 1'b0, pl, rk, lat, er);
    chk("t5_guest_lat", 32'(lat), 32'd1);
    chk("t5_guest_placed", 32'(pl), 32'd0);
    submit(8, 'h4A, 1'b0, 1'b0, pl, rk, lat, er);
    chk("t5_err", 32'(er), 32'd1);
    chk("t5_err_lat", 32'(lat), 32'd1);
    chk_rank_lit(0, 1'b1, 'hCC0C, 'h99);

    abort_test(0, 4, 'h77);
    for (int r = 0; r < N; r++) chk_rank_lit(r, 1'b0, 0, 0);
    submit(4, 'h33, 1'b0, 1'b0, pl, rk, lat, er);
    submit(5, 'h66, 1'b0, 1'b0, pl, rk, lat, er);
    abort_test(1, 6, 'h88);
    for (int r = 0; r < N; r++) chk_rank_lit(r, 1'b0, 0, 0);
    submit(4, 'h21, 1'b0, 1'b0, pl, rk, lat, er);
    abort_test(2, 7, 'h50);

    for (int t = 0; t < 80; t++) begin
      int sc, sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
        abort_test(int'($urandom_range(0, 2)), int'($urandom_range(0, 31)), 'h45);
      end else begin
        if ($urandom_range(0, 7) == 0) sc = int'($urandom_range(0, 255));
        else sc = int'($urandom_range(0, 9)) * 16 + int'($urandom_range(0, 9));
        submit(int'($urandom_range(0, 31)), sc, ($urandom_range(0, 7) == 0),
               1'($urandom), pl, rk, lat, er);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
